// File: rtl/instr_fetch_unit.sv
// Fetch stage: walks the PC through the synchronous program ROM and assembles 1/2-byte instructions.
// Latency 2 (one-byte) / 4 (two-byte) edges to instr_valid; holds the issued instruction while instr_ready is low.
module instr_fetch_unit #(
  parameter logic [6:0] RESET_PC  = 7'h00,
  parameter int         ROM_DEPTH = 128
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  output logic [6:0] instr_pc,
  output logic       illegal,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_addr
);

  typedef enum logic [2:0] {
    S_REQ_OP,
    S_CAP_OP,
    S_REQ_OPND,
    S_CAP_OPND,
    S_ISSUE
  } state_t;

  state_t     state;
  logic [6:0] pc;
  logic [6:0] pc_inc;
  logic       op_two_byte;
  logic       op_one_byte;
  logic       unused_redirect_msb;

  function automatic logic is_two_byte(input logic [7:0] op);
    return op inside {[8'h86:8'h89], [8'h96:8'h98], [8'h20:8'h28]};
  endfunction

  function automatic logic is_one_byte(input logic [7:0] op);
    return op inside {[8'h42:8'h46], 8'h48, [8'h4A:8'h4F]};
  endfunction

  // The ROM only holds ROM_DEPTH words, so the PC wraps at the last word.
  assign pc_inc      = (int'(pc) == ROM_DEPTH - 1) ? 7'h00 : pc + 7'd1;
  assign op_two_byte = is_two_byte(rom_data);
  assign op_one_byte = is_one_byte(rom_data);

  assign unused_redirect_msb = redirect_addr[7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_REQ_OP;
      pc          <= RESET_PC;
      rom_address <= {1'b0, RESET_PC};
      opcode      <= 8'h00;
      operand     <= 8'h00;
      instr_pc    <= 7'h00;
      instr_valid <= 1'b0;
      illegal     <= 1'b0;
    end else if (redirect_valid) begin
      // A redirect in S_ISSUE with instr_ready still consumes the instruction; only the fetch restarts.
      pc          <= redirect_addr[6:0];
      rom_address <= {1'b0, redirect_addr[6:0]};
      state       <= S_REQ_OP;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ_OP: begin
          state <= S_CAP_OP;
        end
        S_CAP_OP: begin
          opcode      <= rom_data;
          instr_pc    <= pc;
          operand     <= 8'h00;
          illegal     <= !(op_two_byte || op_one_byte);
          pc          <= pc_inc;
          rom_address <= {1'b0, pc_inc};
          if (op_two_byte) begin
            state <= S_REQ_OPND;
          end else begin
            state       <= S_ISSUE;
            instr_valid <= 1'b1;
          end
        end
        S_REQ_OPND: begin
          state <= S_CAP_OPND;
        end
        S_CAP_OPND: begin
          operand     <= rom_data;
          pc          <= pc_inc;
          rom_address <= {1'b0, pc_inc};
          state       <= S_ISSUE;
          instr_valid <= 1'b1;
        end
        S_ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= S_REQ_OP;
          end
        end
        default: begin
          state       <= S_REQ_OP;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a behavioural 128x8 synchronous ROM feeds two DUTs (RESET_PC 00 and 7F).
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset, reset_w;
  logic [7:0] rom_address, rom_address_w;
  logic [7:0] rom_data, rom_data_w;
  logic       instr_valid, instr_valid_w;
  logic       instr_ready, instr_ready_w;
  logic [7:0] opcode, opcode_w, operand, operand_w;
  logic [6:0] instr_pc, instr_pc_w;
  logic       illegal, illegal_w;
  logic       redirect_valid, redirect_valid_w;
  logic [7:0] redirect_addr, redirect_addr_w;

  logic [7:0] rom [128];
  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int acc0;

  instr_fetch_unit #(.RESET_PC(7'h00), .ROM_DEPTH(128)) u_dut (
    .clk(clk), .reset(reset), .rom_address(rom_address), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode), .operand(operand),
    .instr_pc(instr_pc), .illegal(illegal), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
  );

  instr_fetch_unit #(.RESET_PC(7'h7F), .ROM_DEPTH(128)) u_wrap (
    .clk(clk), .reset(reset_w), .rom_address(rom_address_w), .rom_data(rom_data_w),
    .instr_valid(instr_valid_w), .instr_ready(instr_ready_w), .opcode(opcode_w), .operand(operand_w),
    .instr_pc(instr_pc_w), .illegal(illegal_w), .redirect_valid(redirect_valid_w), .redirect_addr(redirect_addr_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data   <= rom[rom_address[6:0]];
    rom_data_w <= rom[rom_address_w[6:0]];
  end

  always @(posedge clk) if (instr_valid && instr_ready) accepted <= accepted + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_issue(input string tag, input logic [7:0] op, input logic [7:0] opnd,
                             input logic [6:0] ipc, input logic ill);
    check({tag, "_vld"}, 16'(instr_valid), 16'(1'b1));
    check({tag, "_op"}, 16'(opcode), 16'(op));
    check({tag, "_opnd"}, 16'(operand), 16'(opnd));
    check({tag, "_pc"}, 16'(instr_pc), 16'(ipc));
    check({tag, "_ill"}, 16'(illegal), 16'(ill));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'h42;
    rom[0] = 8'h86; rom[1] = 8'hAA; rom[2] = 8'h96;
    rom[3] = 8'hE0; rom[4] = 8'h20; rom[5] = 8'h00;
    reset = 1'b0; reset_w = 1'b0;
    instr_ready = 1'b1; instr_ready_w = 1'b1;
    redirect_valid = 1'b0; redirect_addr = 8'h00;
    redirect_valid_w = 1'b0; redirect_addr_w = 8'h00;

    // Reset state
    #2;
    check("rst_vld", 16'(instr_valid), 16'(1'b0));
    check("rst_op", 16'(opcode), 16'(8'h00));
    check("rst_opnd", 16'(operand), 16'(8'h00));
    check("rst_ipc", 16'(instr_pc), 16'(7'h00));
    check("rst_ill", 16'(illegal), 16'(1'b0));
    check("rst_addr", 16'(rom_address), 16'(8'h00));

    // Scenario 1: straight-line fetch
    @(posedge clk); #1 reset = 1'b1;
    step(1); check("s1_addr_e1", 16'(rom_address), 16'(8'h00)); check("s1_vld_e1", 16'(instr_valid), 16'(1'b0));
    step(1); check("s1_addr_e2", 16'(rom_address), 16'(8'h01)); check("s1_vld_e2", 16'(instr_valid), 16'(1'b0));
    step(1); check("s1_addr_e3", 16'(rom_address), 16'(8'h01)); check("s1_vld_e3", 16'(instr_valid), 16'(1'b0));
    step(1); check("s1_addr_e4", 16'(rom_address), 16'(8'h02));
    check_issue("s1_i0", 8'h86, 8'hAA, 7'h00, 1'b0);
    step(5); check_issue("s1_i1", 8'h96, 8'hE0, 7'h02, 1'b0);

    // Scenario 2: stall on instruction 96
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_issue("s2_stall", 8'h96, 8'hE0, 7'h02, 1'b0);
      check("s2_addr", 16'(rom_address), 16'(8'h04));
    end
    instr_ready = 1'b1;
    step(5); check_issue("s2_next", 8'h20, 8'h00, 7'h04, 1'b0);

    // Scenario 3a: redirect while fetching the operand of 86; bit 7 of target ignored
    reset = 1'b0; #2 reset = 1'b1;
    step(2); check("s3_addr_opnd", 16'(rom_address), 16'(8'h01));
    redirect_valid = 1'b1; redirect_addr = 8'h84;
    acc0 = accepted;
    step(1); redirect_valid = 1'b0;
    check("s3_addr_redir", 16'(rom_address), 16'(8'h04));
    check("s3_vld_redir", 16'(instr_valid), 16'(1'b0));
    step(3); check("s3_vld_pre", 16'(instr_valid), 16'(1'b0));
    step(1); check_issue("s3_tgt", 8'h20, 8'h00, 7'h04, 1'b0);
    check("s3_no86", 16'(accepted), 16'(acc0));

    // Scenario 3b: redirect together with the issue handshake
    acc0 = accepted;
    redirect_valid = 1'b1; redirect_addr = 8'h04;
    step(1); redirect_valid = 1'b0;
    check("s3b_once", 16'(accepted), 16'(acc0 + 1));
    check("s3b_vld", 16'(instr_valid), 16'(1'b0));
    check("s3b_addr", 16'(rom_address), 16'(8'h04));
    step(4); check_issue("s3b_tgt", 8'h20, 8'h00, 7'h04, 1'b0);

    // Scenario 6: async reset while in S_CAP_OPND
    reset = 1'b0; #2 reset = 1'b1;
    step(3);
    #2 reset = 1'b0;
    #1;
    check("s6_vld", 16'(instr_valid), 16'(1'b0));
    check("s6_op", 16'(opcode), 16'(8'h00));
    check("s6_addr", 16'(rom_address), 16'(8'h00));
    #2 reset = 1'b1;
    step(3); check("s6_vld_pre", 16'(instr_valid), 16'(1'b0));
    step(1); check_issue("s6_i0", 8'h86, 8'hAA, 7'h00, 1'b0);
    step(5); check_issue("s6_i1", 8'h96, 8'hE0, 7'h02, 1'b0);

    // Scenario 5: illegal opcode
    rom[0] = 8'hFF; rom[1] = 8'h42;
    reset = 1'b0; #2 reset = 1'b1;
    step(2); check_issue("s5_ill", 8'hFF, 8'h00, 7'h00, 1'b1);
    step(3); check_issue("s5_next", 8'h42, 8'h00, 7'h01, 1'b0);

    // Scenario 4: PC wrap from 7F on the RESET_PC=7F instance
    reset = 1'b0;
    rom[127] = 8'h46; rom[0] = 8'h88; rom[1] = 8'h5A;
    check("s4_rst_addr", 16'(rom_address_w), 16'(8'h7F));
    #2 reset_w = 1'b1;
    step(1);
    check("s4_addr_e1", 16'(rom_address_w), 16'(8'h7F));
    check("s4_vld_e1", 16'(instr_valid_w), 16'(1'b0));
    step(1);
    check("s4_vld_i0", 16'(instr_valid_w), 16'(1'b1));
    check("s4_op_i0", 16'(opcode_w), 16'(8'h46));
    check("s4_opnd_i0", 16'(operand_w), 16'(8'h00));
    check("s4_pc_i0", 16'(instr_pc_w), 16'(7'h7F));
    check("s4_ill_i0", 16'(illegal_w), 16'(1'b0));
    check("s4_addr_wrap", 16'(rom_address_w), 16'(8'h00));
    step(5);
    check("s4_vld_i1", 16'(instr_valid_w), 16'(1'b1));
    check("s4_op_i1", 16'(opcode_w), 16'(8'h88));
    check("s4_opnd_i1", 16'(operand_w), 16'(8'h5A));
    check("s4_pc_i1", 16'(instr_pc_w), 16'(7'h00));
    check("s4_ill_i1", 16'(illegal_w), 16'(1'b0));
    check("s4_addr_i1", 16'(rom_address_w), 16'(8'h02));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the 8-bit CPU, directly upstream of the 128x8 synchronous program ROM.
- Owns the program counter and drives the ROM address. Captures the ROM's registered read data (1-cycle read latency) and assembles one- or two-byte instructions: opcode plus optional operand.
- Presents each assembled instruction to the decode/execute stage over a valid/ready handshake.
- Accepts branch redirects from execute.

Parameters:
- RESET_PC, 7'h00, PC value loaded on reset.
- ROM_DEPTH, 128, number of ROM words. The PC is 7 bits and wraps modulo ROM_DEPTH.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- rom_address, output, 8, ROM address = {1'b0, pc}; registered.
- rom_data, input, 8, ROM data_out; valid one cycle after rom_address is sampled.
- instr_valid, output, 1, assembled instruction available.
- instr_ready, input, 1, decode accepts the instruction this cycle.
- opcode, output, 8, instruction register.
- operand, output, 8, operand byte; 8'h00 for one-byte instructions.
- instr_pc, output, 7, ROM address of the opcode byte.
- illegal, output, 1, opcode is not in the instruction set; qualified by instr_valid.
- redirect_valid, input, 1, branch taken; load the PC from redirect_addr.
- redirect_addr, input, 8, branch target; bit 7 ignored.

Behaviour:
- Reset (async, reset=0):
  - state=S_REQ_OP, pc=RESET_PC, rom_address={1'b0,RESET_PC}.
  - opcode=0, operand=0, instr_pc=0, instr_valid=0, illegal=0.
  - Outputs take these values immediately, without a clock edge.
- Two-byte opcodes (operand follows): 86-89, 96-98, 20-28.
- One-byte opcodes (no operand): 42-46, 48, 4A-4F.
- Any other value is treated as a one-byte instruction with illegal=1.
- FSM, one transition per clock:
  - S_REQ_OP: ROM samples the pc. Next state is S_CAP_OP.
  - S_CAP_OP: opcode<=rom_data; instr_pc<=pc; operand<=0; pc<=pc+1. Next state is S_REQ_OPND if the opcode is two-byte, otherwise S_ISSUE.
  - S_REQ_OPND: ROM samples the pc. Next state is S_CAP_OPND.
  - S_CAP_OPND: operand<=rom_data; pc<=pc+1. Next state is S_ISSUE.
  - S_ISSUE: instr_valid=1. On instr_ready, go to S_REQ_OP. Otherwise hold, with opcode, operand, instr_pc, illegal and pc all stable.
- instr_valid is registered and asserted only in S_ISSUE.
- Latency, counted as rising edges after reset deassertion until instr_valid is high:
  - one-byte instruction: 2 edges;
  - two-byte instruction: 4 edges.
- Throughput: 3 cycles per one-byte instruction, 5 cycles per two-byte instruction, with instr_ready held high.
- PC arithmetic is 7-bit: 7'h7F+1 = 7'h00. A two-byte instruction at 7F fetches its operand from address 00.
- Redirect has the highest priority after reset and may arrive in any state:
  - pc<=redirect_addr[6:0]; state<=S_REQ_OP; instr_valid<=0.
  - Any partially fetched instruction is discarded.
- Redirect and instr_ready in the same S_ISSUE cycle: the handshake completes, the current instruction counts as consumed, and fetch restarts at the redirect target.
- No combinational path from inputs to outputs.

Test Plan:
1. ROM[0..5]=86,AA,96,E0,20,00, instr_ready=1, release reset:
   - rom_address sequence is 0,0,1,1,2,…
   - first issue is opcode=86, operand=AA, instr_pc=00, instr_valid on the 4th edge;
   - following issues are (96,E0,02), then (20,00,04).
2. Stall: hold instr_ready=0 for 10 cycles during issue of (96,E0):
   - instr_valid stays 1;
   - opcode, operand and instr_pc are unchanged;
   - rom_address stays 04.
   - Release, and the next issue is opcode 20.
3. Redirect: assert redirect_valid with redirect_addr=8'h04 while in S_REQ_OPND for instruction 86:
   - no issue of 86;
   - next issue is (20,00,04).
   - Repeat with redirect in the same cycle as the S_ISSUE handshake: that instruction is accepted once, and the next issue is from 04.
4. Wrap: RESET_PC=7F, ROM[7F]=46, ROM[00]=88, ROM[01]=5A:
   - issue (46,00,7F, illegal=0), then (88,5A,00);
   - rom_address goes 7F to 00.
5. Illegal opcode: ROM[0]=FF, ROM[1]=42:
   - issue opcode FF, operand 00, illegal=1, one-byte;
   - next issue is (42,00,01) with illegal=0.
6. Async reset mid-operation: drop reset during S_CAP_OPND, between clock edges:
   - instr_valid=0, opcode=0 and rom_address=00 with no clock edge;
   - after release, the sequence restarts as in scenario 1.
